// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Holds the FSM state encoding and the default starvation limit.
package mem_arb_pkg;

  localparam int MAX_WAIT_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data-over-instruction grants and raises force_i once
// the instruction side has been passed over MAX_WAIT times in a row.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic grant_i,
  input  logic grant_d,
  output logic force_i
);

  localparam logic [3:0] LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!i_req || grant_i) begin
      wait_cnt_d = '0;
    end else if (grant_d && (wait_cnt_q < LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign force_i = (wait_cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one synchronous
// single-port memory: combinational grant in IDLE, ack one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              i_stall,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       conflict_cnt,
  output state_t            dbg_state
);

  // Handshake: a requester raises req with its command held stable; the
  // command is issued in an IDLE cycle and ack pulses for exactly one cycle
  // after it. A req still high in the ack cycle counts as a fresh request.

  state_t      state_q, state_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;
  logic        in_idle;
  logic        grant_i;
  logic        grant_d;
  logic        force_i;

  mem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .grant_i (grant_i),
    .grant_d (grant_d),
    .force_i (force_i)
  );

  always_comb begin
    in_idle = (state_q == ST_IDLE) && !reset;
    grant_d = in_idle && d_req && !(i_req && force_i);
    grant_i = in_idle && i_req && !grant_d;

    state_d = ST_IDLE;
    if (grant_d) begin
      state_d = ST_BUSY_D;
    end else if (grant_i) begin
      state_d = ST_BUSY_I;
    end

    conflict_cnt_d = conflict_cnt_q;
    if (in_idle && i_req && d_req && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Acks are gated by reset so an in-flight access is dropped silently.
  assign i_ack        = (state_q == ST_BUSY_I) && !reset;
  assign d_ack        = (state_q == ST_BUSY_D) && !reset;
  assign i_rdata      = mem_rdata;
  assign d_rdata      = mem_rdata;
  assign i_stall      = i_req && !i_ack;
  assign d_stall      = d_req && !d_ack;
  assign mem_en       = grant_i || grant_d;
  assign mem_we       = grant_d && d_we;
  assign mem_addr     = grant_d ? d_addr : (grant_i ? i_addr : '0);
  assign mem_wdata    = grant_d ? d_wdata : '0;
  assign conflict_cnt = reset ? '0 : conflict_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_ack, d_ack, i_stall, d_stall, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, conflict_cnt;
  logic [31:0] mem_rdata = '0;
  state_t      dbg_state;

  mem_port_arbiter #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .MAX_WAIT (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_ack        (i_ack),
    .i_rdata      (i_rdata),
    .d_req        (d_req),
    .d_we         (d_we),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_ack        (d_ack),
    .d_rdata      (d_rdata),
    .i_stall      (i_stall),
    .d_stall      (d_stall),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory device ----------------
  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] dev_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) dev_mem[mem_addr] = mem_wdata;
      else mem_rdata <= dev_mem.exists(mem_addr) ? dev_mem[mem_addr] : init_val(mem_addr);
    end
  end

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // ---------------- reference model + compare ----------------
  int          m_busy = 0;   // 0 none, 1 instruction access pending ack, 2 data access
  int          m_wait = 0;   // instruction denials in a row
  logic [31:0] m_conf = '0;
  logic [31:0] m_addr = '0;
  logic        m_rd   = 1'b0;
  bit          preset_req = 1'b0;

  always @(negedge clk) begin
    bit gd, gi, ei, ed;
    gd = 0; gi = 0; ei = 0; ed = 0;
    if (!reset) begin
      if (m_busy == 1) ei = 1;
      else if (m_busy == 2) ed = 1;
      else if (d_req && !(i_req && m_wait == MW)) gd = 1;
      else if (i_req) gi = 1;
    end
    chk("i_ack", 64'(i_ack), 64'(ei));
    chk("d_ack", 64'(d_ack), 64'(ed));
    chk("mem_en", 64'(mem_en), 64'(gd | gi));
    chk("mem_we", 64'(mem_we), 64'(gd & d_we));
    chk("i_stall", 64'(i_stall), 64'(i_req & !ei));
    chk("d_stall", 64'(d_stall), 64'(d_req & !ed));
    chk("conflict_cnt", 64'(conflict_cnt), reset ? 64'd0 : 64'(m_conf));
    if (gd) chk("mem_addr_d", 64'(mem_addr), 64'(d_addr));
    if (gi) chk("mem_addr_i", 64'(mem_addr), 64'(i_addr));
    if (gd && d_we) chk("mem_wdata", 64'(mem_wdata), 64'(d_wdata));
    if (ei) chk("i_rdata", 64'(i_rdata), 64'(ref_rd(m_addr)));
    if (ed && m_rd) chk("d_rdata", 64'(d_rdata), 64'(ref_rd(m_addr)));

    if (reset) begin
      m_busy = 0; m_wait = 0; m_conf = '0;
    end else begin
      if (m_busy == 0 && i_req && d_req && m_conf != 32'hFFFF_FFFF) m_conf = m_conf + 1;
      if (gd) begin
        m_busy = 2; m_addr = d_addr; m_rd = !d_we;
        if (d_we) ref_mem[d_addr] = d_wdata;
        if (i_req && m_wait < MW) m_wait++;
      end else if (gi) begin
        m_busy = 1; m_addr = i_addr; m_wait = 0;
      end else begin
        m_busy = 0;
      end
      if (!i_req) m_wait = 0;
    end
    if (preset_req) m_conf = 32'hFFFF_FFFE;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    i_req = 0; d_req = 0; d_we = 0;
  endtask

  task automatic do_rst(input int n);
    reset = 1;
    idle_in();
    repeat (n) tick();
    reset = 0;
  endtask

  task automatic do_i(input logic [31:0] a, input logic [31:0] exp_d);
    tick();
    i_req = 1; i_addr = a;
    #1;
    chk("i_issue_en", 64'(mem_en), 64'd1);
    chk("i_issue_addr", 64'(mem_addr), 64'(a));
    tick();
    #1;
    chk("i_ack_pulse", 64'(i_ack), 64'd1);
    chk("i_data", 64'(i_rdata), 64'(exp_d));
    i_req = 0;
  endtask

  task automatic do_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_d);
    tick();
    d_req = 1; d_we = we; d_addr = a; d_wdata = wd;
    #1;
    chk("d_issue_en", 64'(mem_en), 64'd1);
    chk("d_issue_we", 64'(mem_we), 64'(we));
    chk("d_issue_addr", 64'(mem_addr), 64'(a));
    tick();
    #1;
    chk("d_ack_pulse", 64'(d_ack), 64'd1);
    if (!we) chk("d_data", 64'(d_rdata), 64'(exp_d));
    d_req = 0; d_we = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    string order;
    logic [7:0] got;
    int n_i;
    order = "DDDDIDDDDI";
    reset = 1; idle_in();
    i_addr = '0; d_addr = '0; d_wdata = '0;

    // reset holds everything quiet even with requests present
    tick();
    i_req = 1; d_req = 1; d_we = 1;
    tick(); tick();
    #1;
    chk("rst_i_ack", 64'(i_ack), 64'd0);
    chk("rst_d_ack", 64'(d_ack), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_conflict", 64'(conflict_cnt), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    idle_in();
    tick();
    reset = 0;

    // single instruction fetch, write then read-back on both ports
    do_i(32'h10, 32'h5A5A_0010);
    do_d(1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0);
    do_d(1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF);
    do_i(32'h40, 32'hDEAD_BEEF);
    do_d(1'b0, 32'h48, 32'h0, 32'h5A5A_0048);

    // continuous contention: forced instruction grant every fifth
    do_rst(2);
    i_addr = 32'h20; d_addr = 32'h80; d_we = 0; i_req = 1; d_req = 1;
    for (int k = 0; k < 10; k++) begin
      #1;
      got = !mem_en ? 8'h2D : (mem_addr == 32'h20) ? 8'h49 : (mem_addr == 32'h80) ? 8'h44 : 8'h3F;
      chk($sformatf("grant_%0d", k), 64'(got), 64'(order[k]));
      tick(); tick();
    end
    #1;
    chk("conflict_10", 64'(conflict_cnt), 64'd10);
    idle_in();

    // reset during a data access aborts it
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h44;
    #1;
    chk("abort_issue", 64'(mem_en), 64'd1);
    tick();
    reset = 1; d_req = 0;
    #1;
    chk("abort_ack0", 64'(d_ack), 64'd0);
    chk("abort_en0", 64'(mem_en), 64'd0);
    chk("abort_stall0", 64'(d_stall), 64'd0);
    tick();
    #1;
    chk("abort_ack1", 64'(d_ack), 64'd0);
    tick();
    reset = 0;
    #1;
    chk("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    chk("abort_no_ack", 64'(d_ack), 64'd0);
    do_d(1'b0, 32'h44, 32'h0, 32'h5A5A_0044);

    // steady fetch with data requests toggling every two cycles
    tick();
    i_addr = 32'h100; d_addr = 32'h104; d_we = 0; i_req = 1;
    n_i = 0;
    for (int c = 0; c < 24; c++) begin
      d_req = c[1];
      #1;
      chk("both_acks", 64'(i_ack & d_ack), 64'd0);
      chk("i_stall_rule", 64'(i_stall), 64'(!i_ack));
      if (i_ack) n_i++;
      tick();
    end
    chk("i_ack_count", 64'(n_i), 64'd6);
    idle_in();

    // conflict counter saturation
    do_rst(2);
    tick();
    force dut.conflict_cnt_d = 32'hFFFF_FFFE;
    preset_req = 1;
    tick();
    release dut.conflict_cnt_d;
    preset_req = 0;
    i_addr = 32'h20; d_addr = 32'h80; d_we = 0; i_req = 1; d_req = 1;
    #1;
    chk("sat_preset", 64'(conflict_cnt), 64'hFFFF_FFFE);
    for (int k = 0; k < 3; k++) begin
      tick(); tick();
      #1;
      chk($sformatf("sat_%0d", k), 64'(conflict_cnt), 64'hFFFF_FFFF);
    end
    idle_in();

    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
